imem_fetch_unit: RTL and testbench

- Instruction-fetch responder at the consumer end of the PC register's address output.
- Takes currPC each cycle and returns the 32-bit instruction to the IF/ID stage.
- Fetches from a variable-latency instruction memory over a req/ack handshake, holding one instruction in a single-entry buffer.
- Drives StallFetch while a fetch is outstanding; the hazard unit folds it into StallF, freezing the PC until the instruction is available.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/imem_fetch_unit_if.sv | 13 +
 rtl/fetch_line_buffer.sv | 36 +++
 rtl/imem_fetch_unit.sv | 99 +++++++++
 tb/tb_imem_fetch_unit.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch responder.
package fetch_pkg;

   localparam int FETCH_ADDR_WIDTH = 32;
   localparam int FETCH_DATA_WIDTH = 32;
   localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/imem_fetch_unit_if.sv
// Request/acknowledge link between the fetch unit (master) and instruction memory (slave).
interface imem_fetch_unit_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  memReq;
   logic [ADDR_WIDTH-1:0] memAddr;
   logic                  memAck;
   logic [DATA_WIDTH-1:0] memRdata;

   modport master (output memReq, output memAddr, input memAck, input memRdata);
   modport slave  (input memReq, input memAddr, output memAck, output memRdata);
endinterface

// File: rtl/fetch_line_buffer.sv
// Single-entry instruction buffer: one write port and a full-width address compare.
module fetch_line_buffer #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [ADDR_WIDTH-1:0] i_lookup_addr,
   output logic                  o_match,
   output logic [DATA_WIDTH-1:0] o_data
);

   logic                  r_buf_valid;
   logic [ADDR_WIDTH-1:0] r_buf_addr;
   logic [DATA_WIDTH-1:0] r_buf_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_buf_valid <= 1'b0;
         r_buf_addr  <= '0;
         r_buf_data  <= NOP_INSTR;
      end else if (i_wr_en) begin
         r_buf_valid <= 1'b1;
         r_buf_addr  <= i_wr_addr;
         r_buf_data  <= i_wr_data;
      end
   end

   assign o_match = r_buf_valid && (r_buf_addr == i_lookup_addr);
   assign o_data  = r_buf_data;

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction-fetch responder: serves currPC from a one-entry buffer, otherwise
// fetches over a req/ack handshake and stalls the PC until the word arrives.
module imem_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = FETCH_ADDR_WIDTH,
   parameter int                    DATA_WIDTH = FETCH_DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = FETCH_NOP_INSTR,
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] i_currPC,
   imem_fetch_unit_if.master     mem,
   output logic [DATA_WIDTH-1:0] o_InstrF,
   output logic                  o_InstrValidF,
   output logic                  o_StallFetch,
   output logic                  o_AlignErrF,
   output logic [CNT_WIDTH-1:0]  o_missCount
);

   // state | meaning
   // IDLE  | no request outstanding; a miss on an aligned PC issues one
   // REQ   | memReq/memAddr held until memAck fills the buffer

   fetch_state_t          r_state;
   logic                  r_mem_req;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [CNT_WIDTH-1:0]  r_miss_count;

   logic                  w_buf_match;
   logic [DATA_WIDTH-1:0] w_buf_data;
   logic                  w_buf_wr;
   logic                  w_align_err;
   logic                  w_hit;
   logic                  w_miss;

   assign w_align_err = |i_currPC[1:0];
   assign w_hit       = w_buf_match && !w_align_err;
   assign w_miss      = !w_hit && !w_align_err;
   // Acks seen outside REQ are spurious and must not touch the buffer.
   assign w_buf_wr    = (r_state == REQ) && mem.memAck;

   fetch_line_buffer #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NOP_INSTR  (NOP_INSTR)
   ) u_line_buffer (
      .clk           (clk),
      .reset         (reset),
      .i_wr_en       (w_buf_wr),
      .i_wr_addr     (r_mem_addr),
      .i_wr_data     (mem.memRdata),
      .i_lookup_addr (i_currPC),
      .o_match       (w_buf_match),
      .o_data        (w_buf_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_mem_req    <= 1'b0;
         r_mem_addr   <= '0;
         r_miss_count <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_miss) begin
                  r_state    <= REQ;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= i_currPC;
                  if (r_miss_count != {CNT_WIDTH{1'b1}})
                     r_miss_count <= r_miss_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
               end
            end
            REQ: begin
               // A redirect does not abort the request; the fill still lands.
               if (mem.memAck) begin
                  r_state   <= IDLE;
                  r_mem_req <= 1'b0;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign mem.memReq    = r_mem_req;
   assign mem.memAddr   = r_mem_addr;
   assign o_InstrF      = w_hit ? w_buf_data : NOP_INSTR;
   assign o_InstrValidF = w_hit;
   assign o_StallFetch  = w_miss;
   assign o_AlignErrF   = w_align_err;
   assign o_missCount   = r_miss_count;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit; inputs change and outputs are sampled on negedge.
module tb_imem_fetch_unit;

   logic        clk;
   logic        reset;
   logic [31:0] currPC;
   logic [31:0] instr_f;
   logic        instr_valid_f;
   logic        stall_fetch;
   logic        align_err_f;
   logic [15:0] miss_count;

   int checks = 0;
   int errors = 0;

   imem_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();

   imem_fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .i_currPC      (currPC),
      .mem           (mem_if.master),
      .o_InstrF      (instr_f),
      .o_InstrValidF (instr_valid_f),
      .o_StallFetch  (stall_fetch),
      .o_AlignErrF   (align_err_f),
      .o_missCount   (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset           = 1'b1;
      currPC          = 32'h0;
      mem_if.memAck   = 1'b0;
      mem_if.memRdata = 32'h0;
      step();
      step();

      // reset state
      check_val("rst_memReq",   32'(mem_if.memReq), 32'd0);
      check_val("rst_memAddr",  mem_if.memAddr, 32'h0);
      check_val("rst_missCnt",  32'(miss_count), 32'd0);
      check_val("rst_valid",    32'(instr_valid_f), 32'd0);
      check_val("rst_instr",    instr_f, 32'h0);

      // basic miss, ack in first REQ cycle
      reset  = 1'b0;
      currPC = 32'h0040_0020;
      #1;
      check_val("t1_stall_n",   32'(stall_fetch), 32'd1);
      check_val("t1_req_n",     32'(mem_if.memReq), 32'd0);
      step();
      check_val("t1_req_n1",    32'(mem_if.memReq), 32'd1);
      check_val("t1_addr_n1",   mem_if.memAddr, 32'h0040_0020);
      check_val("t1_stall_n1",  32'(stall_fetch), 32'd1);
      check_val("t1_cnt_n1",    32'(miss_count), 32'd1);
      mem_if.memAck   = 1'b1;
      mem_if.memRdata = 32'h2008_0005;
      step();
      mem_if.memAck = 1'b0;
      check_val("t1_req_n2",    32'(mem_if.memReq), 32'd0);
      check_val("t1_instr",     instr_f, 32'h2008_0005);
      check_val("t1_valid",     32'(instr_valid_f), 32'd1);
      check_val("t1_stall_n2",  32'(stall_fetch), 32'd0);
      check_val("t1_cnt",       32'(miss_count), 32'd1);

      // hold PC after fill; a spurious ack in IDLE must be ignored
      for (int i = 0; i < 3; i++) begin
         mem_if.memAck   = (i == 1);
         mem_if.memRdata = 32'hFFFF_FFFF;
         step();
         check_val("hold_req",   32'(mem_if.memReq), 32'd0);
         check_val("hold_valid", 32'(instr_valid_f), 32'd1);
         check_val("hold_instr", instr_f, 32'h2008_0005);
         check_val("hold_cnt",   32'(miss_count), 32'd1);
      end
      mem_if.memAck = 1'b0;

      // same address after reset, ack delayed 5 cycles
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check_val("t2_stall_n",   32'(stall_fetch), 32'd1);
      step();
      for (int i = 0; i < 5; i++) begin
         check_val("t2_req_hold",  32'(mem_if.memReq), 32'd1);
         check_val("t2_addr_hold", mem_if.memAddr, 32'h0040_0020);
         check_val("t2_stall",     32'(stall_fetch), 32'd1);
         step();
      end
      check_val("t2_req_last",  32'(mem_if.memReq), 32'd1);
      mem_if.memAck   = 1'b1;
      mem_if.memRdata = 32'h2008_0005;
      step();
      mem_if.memAck = 1'b0;
      check_val("t2_valid",     32'(instr_valid_f), 32'd1);
      check_val("t2_instr",     instr_f, 32'h2008_0005);
      check_val("t2_cnt",       32'(miss_count), 32'd1);

      // redirect while REQ is outstanding
      currPC = 32'h0040_0024;
      #1;
      check_val("t3_stall_n",   32'(stall_fetch), 32'd1);
      step();
      check_val("t3_addr",      mem_if.memAddr, 32'h0040_0024);
      check_val("t3_cnt",       32'(miss_count), 32'd2);
      currPC          = 32'h0040_0100;
      mem_if.memAck   = 1'b1;
      mem_if.memRdata = 32'hAAAA_0000;
      #1;
      check_val("t3_addr_hold", mem_if.memAddr, 32'h0040_0024);
      check_val("t3_valid_ack", 32'(instr_valid_f), 32'd0);
      step();
      mem_if.memAck = 1'b0;
      check_val("t3_valid_idle", 32'(instr_valid_f), 32'd0);
      check_val("t3_stall_idle", 32'(stall_fetch), 32'd1);
      check_val("t3_req_idle",   32'(mem_if.memReq), 32'd0);
      currPC = 32'h0040_0024;
      #1;
      check_val("t3_buf_instr",  instr_f, 32'hAAAA_0000);
      check_val("t3_buf_valid",  32'(instr_valid_f), 32'd1);
      currPC = 32'h0040_0100;
      step();
      check_val("t3_req_new",    32'(mem_if.memReq), 32'd1);
      check_val("t3_addr_new",   mem_if.memAddr, 32'h0040_0100);
      check_val("t3_cnt_new",    32'(miss_count), 32'd3);
      mem_if.memAck   = 1'b1;
      mem_if.memRdata = 32'h8C02_0000;
      step();
      mem_if.memAck = 1'b0;
      check_val("t3_instr_new",  instr_f, 32'h8C02_0000);

      // misaligned PC: no request, no stall
      currPC = 32'h0040_0022;
      #1;
      check_val("t4_align",     32'(align_err_f), 32'd1);
      check_val("t4_stall",     32'(stall_fetch), 32'd0);
      check_val("t4_instr",     instr_f, 32'h0);
      check_val("t4_valid",     32'(instr_valid_f), 32'd0);
      step();
      step();
      check_val("t4_req",       32'(mem_if.memReq), 32'd0);
      check_val("t4_cnt",       32'(miss_count), 32'd3);

      // reset during REQ; ack arriving after reset is ignored
      currPC = 32'h0040_0200;
      step();
      check_val("t5_req_pre",   32'(mem_if.memReq), 32'd1);
      check_val("t5_cnt_pre",   32'(miss_count), 32'd4);
      reset = 1'b1;
      step();
      reset           = 1'b0;
      mem_if.memAck   = 1'b1;
      mem_if.memRdata = 32'hDEAD_BEEF;
      check_val("t5_req_rst",   32'(mem_if.memReq), 32'd0);
      check_val("t5_cnt_rst",   32'(miss_count), 32'd0);
      currPC = 32'h0040_0100;
      #1;
      check_val("t5_buf_clr",   32'(instr_valid_f), 32'd0);
      currPC = 32'h0040_0200;
      step();
      mem_if.memAck = 1'b0;
      check_val("t5_req_new",   32'(mem_if.memReq), 32'd1);
      check_val("t5_valid",     32'(instr_valid_f), 32'd0);
      check_val("t5_instr",     instr_f, 32'h0);
      check_val("t5_cnt_new",   32'(miss_count), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
